// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes, and the select/operation codes driven onto the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR     = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IALU   = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IALU, OP_AUIPC, OP_STORE, OP_RTYPE,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_supported = 1'b1;
            default:                            is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-format select, decoded purely from the opcode so the
// immediate is valid in every state, including DECODE.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] ImmSrc
);

    // Map opcode to immediate format; unknown opcodes fall back to I-type.
    always_comb begin
        ImmSrc = IMM_I;
        case (opcode)
            OP_STORE:          ImmSrc = IMM_S;
            OP_BRANCH:         ImmSrc = IMM_B;
            OP_JAL:            ImmSrc = IMM_J;
            OP_LUI, OP_AUIPC:  ImmSrc = IMM_U;
            default:           ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4 when memory ready
//   DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
//   MEMADR   | ALUOut <= rs1+imm (load/store address)
//   MEMREAD  | read data memory, wait for MemReady
//   MEMWB    | rd <= read data
//   MEMWRITE | write data memory until MemReady
//   EXECR    | ALUOut <= rs1 op rs2
//   EXECI    | ALUOut <= rs1 op imm
//   ALUWB    | rd <= ALUOut
//   BRANCH   | compare rs1/rs2, PC <= branch target if taken
//   JALR     | ALUOut <= rs1+imm (jump target)
//   JAL      | PC <= ALUOut, ALUOut <= OldPC+4 (link value)
//   LUI      | ALUOut <= 0+imm
//
// Several outputs depend on MemReady/BranchTaken/opcode in the current
// cycle, so the datapath controls are decoded combinationally from the
// state register; the write enables are forced low while reset is high.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       BranchTaken,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       InstrDone,
    output logic       IllegalInstr
);

    state_t state;

    logic pc_we;
    logic ir_we;
    logic reg_we;
    logic mem_we;
    logic done;
    logic illegal;

    imm_src_decoder u_imm_src_decoder (
        .opcode (opcode),
        .ImmSrc (ImmSrc)
    );

    // State register and next-state logic; reset aborts any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_IALU:           state <= S_EXECI;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
                        OP_JALR:           state <= S_JALR;
                        OP_LUI:            state <= S_LUI;
                        OP_AUIPC:          state <= S_ALUWB;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (MemReady) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (MemReady) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JALR:     state <= S_JAL;
                S_JAL:      state <= S_ALUWB;
                S_LUI:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; anything not set stays at zero.
    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = ADR_PC;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                pc_we     = MemReady;
                ir_we     = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                illegal = ~is_supported(opcode);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = ADR_ALUOUT;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                reg_we    = 1'b1;
                done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = ADR_ALUOUT;
                mem_we = 1'b1;
                done   = MemReady;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_we = 1'b1;
                done   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_BRANCH;
                pc_we   = BranchTaken;
                done    = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pc_we   = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            default: begin
                pc_we = 1'b0;
            end
        endcase
    end

    // Write enables and pulses are suppressed during reset so an aborted
    // instruction never commits architectural state.
    assign PCWrite      = pc_we   & ~reset;
    assign IRWrite      = ir_we   & ~reset;
    assign RegWrite     = reg_we  & ~reset;
    assign MemWrite     = mem_we  & ~reset;
    assign InstrDone    = done    & ~reset;
    assign IllegalInstr = illegal & ~reset;

endmodule
